iter_mdu: RTL and testbench
===========================

ITER_MDU -- requirements
Module: iter_mdu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and HI/LO width; legal range 8..64, even values only.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port clr  input  1  synchronous exception abort of any in-flight operation.
REQ-005 SHALL provide port start  input  1  launch request; op, src_a and src_b are sampled when it is accepted.
REQ-006 SHALL provide port op  input  4  operation code: 0000 multu, 0001 mult, 0010 divu, 0011 div, 0100 maddu, 0101 madd, 0110 msubu, 0111 msub.
REQ-007 SHALL provide ports src_a and src_b  input  WIDTH  operands; src_a is also the data source for mthi and mtlo.
REQ-008 SHALL provide ports mthi and mtlo  input  1  write src_a into HI or LO respectively.
REQ-009 SHALL provide ports hi and lo  output  WIDTH  architectural HI and LO registers.
REQ-010 SHALL provide port busy  output  1  high while an operation is in flight.
REQ-011 SHALL provide port done  output  1  one-cycle pulse in the cycle after HI/LO commit.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX; transitions: IDLE->CALC on accepted start, CALC->FIX after WIDTH iterations, FIX->IDLE unconditionally.
REQ-013 SHALL accept start only in IDLE with clr low; a start while busy SHALL be ignored, with no queuing.
REQ-014 SHALL ignore op codes 1000-1111: no state change, busy stays low.
REQ-015 SHALL compute with a radix-2 shift-add multiplier and a restoring divider on operand magnitudes, applying sign correction in FIX.
REQ-016 SHALL hold busy high from the acceptance edge through the FIX edge; on the FIX edge HI/LO are written, busy falls and done rises, giving a total latency of WIDTH+2 edges from start.
REQ-017 SHALL use, for mult/multu, {hi,lo} = full 2*WIDTH-bit product, signed or zero-extended.
REQ-018 SHALL truncate div quotients toward zero: lo = quotient, hi = remainder, remainder sign following the dividend; divu is unsigned.
REQ-019 SHALL return lo = most-negative value and hi = 0 for signed most-negative / -1, with no trap.
REQ-020 SHALL handle divide by zero (signed or unsigned) by skipping CALC: hi = src_a, lo = all ones, done after 2 edges.
REQ-021 SHALL have madd/maddu/msub/msubu add the product to, or subtract it from, the {hi,lo} value captured at start, modulo 2^(2*WIDTH).
REQ-022 SHALL apply mthi/mtlo at the next edge only in IDLE with start low; if start and mthi/mtlo are both high, start wins and the move is dropped; moves while busy are dropped.
REQ-023 SHALL, on clr in any state, go to IDLE at the next edge, leave hi/lo unchanged and suppress done; clr beats a simultaneous start.
REQ-024 SHALL keep hi/lo stable (old values) throughout CALC; only the FIX edge or a move changes them.

Reset
REQ-025 SHALL, on reset assertion, immediately and without waiting for clk set state=IDLE, hi=0, lo=0, busy=0, done=0 and clear the iteration counter and temporaries.
REQ-026 SHALL, on reset mid-operation, discard the operation with no done pulse; the first start after deassertion SHALL operate normally.

Structure
REQ-027 SHALL place op encodings and the state enum in shared package mdu_pkg.
REQ-028 SHALL place the divider datapath (remainder/quotient shift register, step counter) in sub-module iter_div_core; the multiplier stays inline.

Verification
REQ-029 SHALL cover: mult 0xFFFFFFFF*0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done 34 edges after start; multu same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-030 SHALL cover: div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 SHALL cover: divu 5/0 -> hi=5, lo=0xFFFFFFFF, done 2 edges after start, busy never exceeding 2 cycles.
REQ-032 SHALL cover: mtlo 0xFFFFFFFF, mthi 0, then maddu 1*1 -> hi=1, lo=0; then msub 1*1 -> hi=0, lo=0xFFFFFFFF.
REQ-033 SHALL cover: start mult, clr on cycle 10 -> busy low next cycle, hi/lo unchanged, no done; a start issued during busy is ignored.
REQ-034 SHALL cover: reset pulse between clk edges mid-divide -> busy, hi and lo go to 0 before the next edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the operation encodings, the controller state enum and small
// op-decoding helpers so the unit and its bench agree on one encoding.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_MULTU = 4'b0000,
        OP_MULT  = 4'b0001,
        OP_DIVU  = 4'b0010,
        OP_DIV   = 4'b0011,
        OP_MADDU = 4'b0100,
        OP_MADD  = 4'b0101,
        OP_MSUBU = 4'b0110,
        OP_MSUB  = 4'b0111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // Codes with the top bit set are reserved and never launch anything.
    function automatic logic op_valid(input logic [3:0] op);
        return !op[3];
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    // Odd codes are the signed variants.
    function automatic logic op_is_signed(input logic [3:0] op);
        return op[0];
    endfunction

    // madd/maddu/msub/msubu accumulate into {hi,lo}.
    function automatic logic op_is_acc(input logic [3:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_sub(input logic [3:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/iter_div_core.sv
// iter_div_core: restoring divider on unsigned magnitudes, one quotient bit
// per step, plus the step counter that paces every iterative operation.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   load                capture dividend/divisor and restart the step count
//   step                perform one restoring step
//   dividend, divisor   unsigned magnitudes (sampled on load)
//   quotient, remainder results, valid after WIDTH steps
//   last                the current step is the WIDTH-th one
module iter_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Shift the next dividend bit into the partial remainder and try the
    // subtraction. When it fits the true difference is below the divisor,
    // so the low WIDTH bits of the wrapped subtraction are exact.
    // NOTE: every signal written in always_comb is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dsr_q});
        diff    = shifted[WIDTH-1:0] - dsr_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= fits ? diff : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], fits};
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/iter_mdu.sv
// iter_mdu: iterative multiply/divide unit with architectural HI/LO.
// A radix-2 shift-add multiplier (inline) and a restoring divider
// (iter_div_core) work on operand magnitudes for WIDTH steps; signs and
// accumulation are applied in a single FIX cycle that also commits HI/LO.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   clr             synchronous abort of any in-flight operation
//   start, op       launch request and operation code (mdu_pkg::mdu_op_e)
//   src_a, src_b    operands; src_a also feeds mthi/mtlo
//   mthi, mtlo      move src_a into HI / LO (idle only, start low)
//   hi, lo          architectural HI and LO
//   busy            operation in flight
//   done            one-cycle pulse after HI/LO commit
//
// WIDTH must be even and within 8..64.
module iter_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    mdu_state_e         state;
    logic [3:0]         op_q;
    logic               neg_res;   // product / quotient needs negation
    logic               neg_rem;   // remainder follows dividend sign
    logic               div0;
    logic [WIDTH-1:0]   mcand;
    // Multiplier: {partial sum, remaining multiplier bits}. For divides the
    // low half instead keeps the raw dividend for the divide-by-zero result.
    logic [2*WIDTH-1:0] prod;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_signed;
    logic [2*WIDTH-1:0] mul_fix;
    logic [WIDTH-1:0]   quotient, remainder;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               last;

    always_comb begin
        a_neg  = op_is_signed(op) & src_a[WIDTH-1];
        b_neg  = op_is_signed(op) & src_b[WIDTH-1];
        a_mag  = a_neg ? -src_a : src_a;
        b_mag  = b_neg ? -src_b : src_b;
        accept = (state == IDLE) && start && !clr && op_valid(op);

        mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

        // HI/LO cannot change while busy, so the current {hi,lo} is still
        // the value captured at start when FIX accumulates into it.
        prod_signed = neg_res ? -prod : prod;
        if (!op_is_acc(op_q))
            mul_fix = prod_signed;
        else if (op_is_sub(op_q))
            mul_fix = {hi, lo} - prod_signed;
        else
            mul_fix = {hi, lo} + prod_signed;

        quo_fix = neg_res ? -quotient : quotient;
        rem_fix = neg_rem ? -remainder : remainder;
    end

    // The divider's step counter also paces the multiplier: both run
    // exactly WIDTH steps in CALC.
    iter_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .step      ((state == CALC) && !clr),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quotient),
        .remainder (remainder),
        .last      (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            mcand   <= '0;
            prod    <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (clr) begin
            // Abort: drop the operation, keep HI/LO, no done pulse.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // A start, even a reserved one, drops any move.
                        if (op_valid(op)) begin
                            op_q    <= op;
                            busy    <= 1'b1;
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            mcand   <= a_mag;
                            if (op_is_div(op)) begin
                                div0  <= (src_b == '0);
                                prod  <= {{WIDTH{1'b0}}, src_a};
                                state <= (src_b == '0) ? FIX : CALC;
                            end else begin
                                div0  <= 1'b0;
                                prod  <= {{WIDTH{1'b0}}, b_mag};
                                state <= CALC;
                            end
                        end
                    end else begin
                        if (mthi) hi <= src_a;
                        if (mtlo) lo <= src_a;
                    end
                end
                CALC: begin
                    if (!op_is_div(op_q))
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    if (last)
                        state <= FIX;
                end
                FIX: begin
                    if (op_is_div(op_q)) begin
                        if (div0) begin
                            hi <= prod[WIDTH-1:0];
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        {hi, lo} <= mul_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mdu.sv
// tb_iter_mdu: self-checking bench for iter_mdu (WIDTH = 32). Expected HI/LO
// come from plain 64-bit arithmetic on the architectural definition of each
// operation; latency, busy, done, moves, clr and reset are checked directly.
module tb_iter_mdu;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, clr, start, mthi, mtlo;
    logic [3:0]   op;
    logic [W-1:0] src_a, src_b, hi, lo;
    logic         busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] m_hi, m_lo;

    always #5 clk = ~clk;

    iter_mdu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result {hi,lo} from the operation definitions.
    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [W-1:0] h,
                                               input logic [W-1:0] l);
        longint       sa, sb;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = o[0] ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});
        case (o)
            OP_MULTU, OP_MULT: return p;
            OP_MADDU, OP_MADD: return {h, l} + p;
            OP_MSUBU, OP_MSUB: return {h, l} - p;
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: return {h, l};
        endcase
    endfunction

    // Launch one operation and follow it to done. With poke set, a competing
    // start and an mthi are raised mid-operation; both must be ignored.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit poke);
        logic [63:0]  exp;
        int           lat, elat;
        bit           stable;
        logic [W-1:0] h0, l0;
        exp    = ref_result(o, a, b, m_hi, m_lo);
        elat   = ((o == OP_DIVU || o == OP_DIV) && b == 0) ? 2 : W + 2;
        h0     = hi;
        l0     = lo;
        stable = 1'b1;
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        check({tag, "_busy"}, busy, 1);
        while (!done && lat < 200) begin
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            if (poke && lat == 5) begin
                start = 1'b1; op = OP_MULTU; src_a = $urandom; src_b = $urandom; mthi = 1'b1;
            end
            if (poke && lat == 7) begin
                start = 1'b0; mthi = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_stable"}, stable, 1);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_hi"}, hi, exp[63:32]);
        check({tag, "_lo"}, lo, exp[31:0]);
        check({tag, "_busyoff"}, busy, 0);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        @(posedge clk); #1;
        check({tag, "_pulse"}, done, 0);
        check({tag, "_noqueue"}, busy, 0);
    endtask

    task automatic do_move(input bit to_hi, input logic [W-1:0] v);
        @(negedge clk);
        src_a = v; mthi = to_hi; mtlo = !to_hi;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        if (to_hi) m_hi = v; else m_lo = v;
        check("mv_hi", hi, m_hi);
        check("mv_lo", lo, m_lo);
    endtask

    function automatic logic [W-1:0] pick_operand(input int sel);
        case (sel)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'(int'($urandom_range(0, 15)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           saw_done;
        logic [W-1:0] h0, l0;
        reset = 1'b1; clr = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = '0; src_a = '0; src_b = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // Directed signed/unsigned multiply and divide corners.
        do_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0);
        check("mult_hi_k", hi, 32'hFFFF_FFFF);
        check("mult_lo_k", lo, 32'hFFFF_FFFE);
        do_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0);
        check("multu_hi_k", hi, 32'h1);
        do_op("div_m7", OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0);
        check("div_m7_lo_k", lo, 32'hFFFF_FFFD);
        check("div_m7_hi_k", hi, 32'hFFFF_FFFF);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo_k", lo, 32'h8000_0000);
        check("div_ovf_hi_k", hi, 32'h0);
        do_op("divu_z", OP_DIVU, 32'h5, 32'h0, 1'b0);
        check("divu_z_hi_k", hi, 32'h5);
        check("divu_z_lo_k", lo, 32'hFFFF_FFFF);

        // Moves followed by accumulate / subtract across the LO/HI carry.
        do_move(1'b0, 32'hFFFF_FFFF);
        do_move(1'b1, 32'h0);
        do_op("maddu", OP_MADDU, 32'h1, 32'h1, 1'b0);
        check("maddu_k", {hi, lo}, 64'h1_0000_0000);
        do_op("msub", OP_MSUB, 32'h1, 32'h1, 1'b0);
        check("msub_k", {hi, lo}, 64'h0000_0000_FFFF_FFFF);

        // Start and move while busy are ignored.
        do_op("poke", OP_MADD, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);

        // Reserved op codes launch nothing.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op = 4'(8 + $urandom_range(0, 7)); start = 1'b1; mthi = 1'b1; src_a = $urandom;
            @(posedge clk); #1;
            start = 1'b0; mthi = 1'b0;
            check("rsv_busy", busy, 0);
            check("rsv_hilo", {hi, lo}, {m_hi, m_lo});
        end

        // clr on cycle 10 of a multiply.
        h0 = hi; l0 = lo;
        @(negedge clk);
        op = OP_MULT; src_a = 32'h7; src_b = 32'h9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_hilo", {hi, lo}, {h0, l0});
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("clr_nodone", saw_done, 0);
        check("clr_hilo2", {hi, lo}, {h0, l0});

        // Asynchronous reset between edges during a divide.
        do_move(1'b1, 32'hA5A5_0001);
        do_move(1'b0, 32'h5A5A_0002);
        @(negedge clk);
        op = OP_DIV; src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("arst_nodone", saw_done, 0);
        do_op("post_rst", OP_DIVU, 32'd1000, 32'd7, 1'b0);

        // Randomized operations with occasional moves in between.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0)
                do_move(1'($urandom_range(0, 1)), $urandom);
            do_op("rnd", 4'($urandom_range(0, 7)),
                  pick_operand($urandom_range(0, 7)), pick_operand($urandom_range(0, 7)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
